coin_accumulator: RTL
=====================

COIN_ACCUMULATOR -- requirements
Module: coin_accumulator

Parameters
REQ-001 SHALL provide MAX_CREDIT, default 15, maximum accumulated credit in units (at most 15, fits 4 bits).
REQ-002 SHALL provide TIMEOUT, default 1000, number of idle cycles in COLLECT before automatic refund (at least 2).

Interface
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 coin_valid  in  1  one-cycle pulse, coin inserted.
REQ-006 coin_type  in  2  00=1 unit, 01=2 units, 10=5 units, 11=invalid; sampled when coin_valid=1.
REQ-007 cancel  in  1  one-cycle pulse, user requests refund.
REQ-008 vend_lock  in  1  level, downstream vend FSM has taken the credit.
REQ-009 vend_done  in  1  one-cycle pulse, downstream vend finished.
REQ-010 change  in  4  units to return; sampled when vend_done=1.
REQ-011 credit  out  4  registered accumulated credit; feeds downstream coins input.
REQ-012 credit_valid  out  1  registered, 1 when credit>0 and state is COLLECT or VEND.
REQ-013 coin_reject  out  1  registered one-cycle pulse, coin returned unaccepted.
REQ-014 refund_valid  out  1  registered one-cycle pulse, refund_amt valid.
REQ-015 refund_amt  out  4  registered units to return; 0 when refund_valid=0.

Function
REQ-016 SHALL implement four states: IDLE (credit=0), COLLECT, VEND, REFUND.
REQ-017 Accepted coin SHALL increase credit by its value on the next clock edge; latency 1 cycle.
REQ-018 Coin acceptance: SHALL accept only when state is IDLE or COLLECT, coin_type≠11, and credit+value≤MAX_CREDIT; sum computed in 5 bits, no wrap.
REQ-019 Rejected coin SHALL leave credit unchanged and pulse coin_reject for exactly 1 cycle, registered one cycle after coin_valid.
REQ-020 IDLE->COLLECT on the first accepted coin.
REQ-021 COLLECT->REFUND on cancel: refund_amt=credit and credit=0, both registered with the state change.
REQ-022 COLLECT SHALL hold an idle counter, cleared on every accepted coin.
REQ-023 When the idle counter reaches TIMEOUT-1 with no coin, COLLECT->REFUND as for cancel.
REQ-024 cancel in IDLE SHALL be ignored: no refund pulse.
REQ-025 COLLECT->VEND when vend_lock=1.
REQ-026 In VEND: credit held; coins rejected; cancel ignored; idle counter frozen.
REQ-027 VEND->REFUND on vend_done: refund_amt=change, credit=0.
REQ-028 If change=0, VEND->IDLE instead; no refund pulse.
REQ-029 vend_lock deasserted in VEND without vend_done SHALL return the block to COLLECT with credit retained.
REQ-030 REFUND lasts exactly 1 cycle: refund_valid=1, then state->IDLE.
REQ-031 Coins arriving during REFUND SHALL be rejected.
REQ-032 Simultaneous coin_valid and cancel in COLLECT: cancel wins; coin rejected; refund_amt excludes that coin.
REQ-033 Simultaneous coin_valid and the timeout cycle: coin accepted; counter cleared; no refund.
REQ-034 vend_done outside VEND SHALL be ignored.
REQ-035 vend_lock in IDLE SHALL be ignored.
REQ-036 Credit SHALL never exceed MAX_CREDIT and never underflow.

Reset
REQ-037 reset=1 SHALL asynchronously force state=IDLE, credit=0, credit_valid=0, coin_reject=0, refund_valid=0, refund_amt=0, idle counter=0.
REQ-038 Reset mid-VEND or mid-REFUND SHALL discard credit with no refund pulse.
REQ-039 First state update SHALL occur on the first rising clk edge after reset deasserts.

Verification
REQ-040 Coins 5,2,1 on consecutive cycles -> credit 5,7,8 one cycle after each; credit_valid=1 from the first.
REQ-041 Credit 14 plus a 2-unit coin -> coin_reject pulse; credit stays 14. Then a 1-unit coin -> credit 15.
REQ-042 Credit 7, then coin and cancel in the same cycle -> refund_valid=1 with refund_amt=7 for 1 cycle; coin_reject=1; then IDLE with credit 0.
REQ-043 TIMEOUT=4, credit 3, no activity -> refund_valid with refund_amt=3, 4 cycles after the last coin; then IDLE.
REQ-044 Credit 10, vend_lock=1, a coin during VEND (rejected), then vend_done with change=0 -> IDLE, credit 0, no refund. Repeat with credit 12, change=2 -> refund_amt=2.
REQ-045 Assert reset asynchronously mid-VEND with credit 9 -> all outputs 0 immediately, before any clock edge; no refund pulse after release.

Source files
------------

// File: rtl/coin_accumulator.sv
// Coin accumulator: collects coin credit for a downstream vend FSM, hands the
// credit over while vending, and returns change or the unspent credit as a
// one-cycle refund pulse. Cancel and an idle timeout both trigger a refund.
module coin_accumulator #(
    parameter int MAX_CREDIT = 15,   // maximum accumulated credit, <= 15
    parameter int TIMEOUT    = 1000  // idle cycles in COLLECT before refund, >= 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       cancel,
    input  logic       vend_lock,
    input  logic       vend_done,
    input  logic [3:0] change,
    output logic [3:0] credit,
    output logic       credit_valid,
    output logic       coin_reject,
    output logic       refund_valid,
    output logic [3:0] refund_amt
);

    localparam int             CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [4:0]     MAX_C    = 5'(MAX_CREDIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_VEND,
        ST_REFUND
    } state_t;

    state_t           state_reg,        state_next;
    logic [3:0]       credit_reg,       credit_next;
    logic             credit_valid_reg, credit_valid_next;
    logic             coin_reject_reg,  coin_reject_next;
    logic             refund_valid_reg, refund_valid_next;
    logic [3:0]       refund_amt_reg,   refund_amt_next;
    logic [CNT_W-1:0] idle_cnt_reg,     idle_cnt_next;

    // Coin value lookup indexed by coin_type; code 3 is the invalid coin.
    logic [2:0] coin_lut [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_coin_lut
            assign coin_lut[gi] = (gi == 0) ? 3'd1 :
                                  (gi == 1) ? 3'd2 :
                                  (gi == 2) ? 3'd5 : 3'd0;
        end
    endgenerate

    logic [2:0] coin_value;
    logic [4:0] credit_sum;
    logic       coin_fits;

    // Sum is formed one bit wider than credit so an overflowing coin is
    // seen as too large rather than wrapping to a small value.
    always_comb begin
        coin_value = coin_lut[coin_type];
        credit_sum = {1'b0, credit_reg} + {2'b00, coin_value};
        coin_fits  = (coin_type != 2'b11) && (credit_sum <= MAX_C);
    end

    logic coin_accept;

    // Next-state and registered-output logic.
    always_comb begin
        state_next        = state_reg;
        credit_next       = credit_reg;
        idle_cnt_next     = idle_cnt_reg;
        refund_valid_next = 1'b0;
        refund_amt_next   = 4'd0;
        coin_accept       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // cancel, vend_lock and vend_done have no meaning without credit
                if (coin_valid && coin_fits) begin
                    coin_accept   = 1'b1;
                    credit_next   = credit_sum[3:0];
                    idle_cnt_next = '0;
                    state_next    = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (cancel) begin
                    // cancel beats a simultaneous coin: refund what was held
                    refund_valid_next = 1'b1;
                    refund_amt_next   = credit_reg;
                    credit_next       = 4'd0;
                    idle_cnt_next     = '0;
                    state_next        = ST_REFUND;
                end else begin
                    if (coin_valid && coin_fits) begin
                        // a coin on the timeout cycle still wins over the refund
                        coin_accept   = 1'b1;
                        credit_next   = credit_sum[3:0];
                        idle_cnt_next = '0;
                    end else if (!vend_lock) begin
                        if (idle_cnt_reg == CNT_LAST) begin
                            refund_valid_next = 1'b1;
                            refund_amt_next   = credit_reg;
                            credit_next       = 4'd0;
                            idle_cnt_next     = '0;
                            state_next        = ST_REFUND;
                        end else begin
                            idle_cnt_next = idle_cnt_reg + 1'b1;
                        end
                    end
                    if (vend_lock) begin
                        state_next = ST_VEND;
                    end
                end
            end

            ST_VEND: begin
                // credit and idle counter are frozen while downstream vends
                if (vend_done) begin
                    credit_next   = 4'd0;
                    idle_cnt_next = '0;
                    if (change == 4'd0) begin
                        state_next = ST_IDLE;
                    end else begin
                        refund_valid_next = 1'b1;
                        refund_amt_next   = change;
                        state_next        = ST_REFUND;
                    end
                end else if (!vend_lock) begin
                    state_next = ST_COLLECT;
                end
            end

            ST_REFUND: begin
                credit_next   = 4'd0;
                idle_cnt_next = '0;
                state_next    = ST_IDLE;
            end

            default: begin
                credit_next   = 4'd0;
                idle_cnt_next = '0;
                state_next    = ST_IDLE;
            end
        endcase

        coin_reject_next  = coin_valid && !coin_accept;
        credit_valid_next = (credit_next != 4'd0) &&
                            ((state_next == ST_COLLECT) || (state_next == ST_VEND));
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            credit_reg       <= 4'd0;
            credit_valid_reg <= 1'b0;
            coin_reject_reg  <= 1'b0;
            refund_valid_reg <= 1'b0;
            refund_amt_reg   <= 4'd0;
            idle_cnt_reg     <= '0;
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            credit_valid_reg <= credit_valid_next;
            coin_reject_reg  <= coin_reject_next;
            refund_valid_reg <= refund_valid_next;
            refund_amt_reg   <= refund_amt_next;
            idle_cnt_reg     <= idle_cnt_next;
        end
    end

    assign credit       = credit_reg;
    assign credit_valid = credit_valid_reg;
    assign coin_reject  = coin_reject_reg;
    assign refund_valid = refund_valid_reg;
    assign refund_amt   = refund_amt_reg;

endmodule
